acc_load_unit: RTL and testbench

//  Parametrised successor of the accumulator source selector in the 8-bit CPU datapath.

---
 rtl/acc_load_pkg.sv | 14 +
 rtl/acc_src_sel.sv | 22 ++
 rtl/acc_load_unit.sv | 111 +++++++++++
 tb/tb_acc_load_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/acc_load_pkg.sv
// Shared op and FSM state encodings for the accumulator load unit.
package acc_load_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_DEC   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/acc_src_sel.sv
// NSRC:1 WIDTH-bit source mux; selecting a missing channel yields 0 and raises oor_o.
module acc_src_sel #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC*WIDTH-1:0] src_i,
  input  logic [SELW-1:0]       sel_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  oor_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_i == SELW'(k)) data_o = src_i[k*WIDTH +: WIDTH];
    end
  end

  assign oor_o = (int'(sel_i) >= NSRC);

endmodule

// File: rtl/acc_load_unit.sv
// Accumulator source selector with valid/ready request port and one-entry output hold.
// Build option: ACC_LOAD_SAT_EN makes INC/DEC saturate instead of wrap.
module acc_load_unit
  import acc_load_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       src_sel,
  input  logic [1:0]            op,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [WIDTH-1:0]      aout,
  output logic                  aout_valid,
  input  logic                  out_ack,
  output logic                  zero,
  output logic                  carry,
  output logic                  sel_err
);

  function automatic logic [WIDTH-1:0] inc_f(input logic [WIDTH-1:0] a);
`ifdef ACC_LOAD_SAT_EN
    return (&a) ? a : a + WIDTH'(1);
`else
    return a + WIDTH'(1);
`endif
  endfunction

  function automatic logic [WIDTH-1:0] dec_f(input logic [WIDTH-1:0] a);
`ifdef ACC_LOAD_SAT_EN
    return (~|a) ? a : a - WIDTH'(1);
`else
    return a - WIDTH'(1);
`endif
  endfunction

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               zero_q, carry_q, carry_d, err_q, err_d;
  logic [WIDTH-1:0]   mux_data;
  logic               mux_oor;
  logic               accept;

  acc_src_sel #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_sel (
    .src_i  (src_data),
    .sel_i  (src_sel),
    .data_o (mux_data),
    .oor_o  (mux_oor)
  );

  // Ready passes through in the same cycle the held result is acknowledged.
  assign req_ready = (state_q == ST_IDLE) || out_ack;
  assign accept    = req_valid && req_ready;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    err_d   = err_q;
    if (accept) begin
      carry_d = 1'b0;
      err_d   = 1'b0;
      case (op)
        OP_LOAD: begin
          acc_d = mux_data;
          err_d = mux_oor;
        end
        OP_CLEAR: acc_d = '0;
        OP_INC: begin
          acc_d   = inc_f(acc_q);
          carry_d = &acc_q;
        end
        OP_DEC: begin
          acc_d   = dec_f(acc_q);
          carry_d = ~|acc_q;
        end
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_FULL;
        ST_FULL: if (!accept && out_ack) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      acc_q   <= acc_d;
      zero_q  <= (acc_d == '0);
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign aout       = acc_q;
  assign aout_valid = (state_q == ST_FULL);
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign sel_err    = err_q;

endmodule

// File: tb/tb_acc_load_unit.sv
// Directed table-driven bench for acc_load_unit (default NSRC=4 plus an NSRC=5 instance).
module tb_acc_load_unit;
  import acc_load_pkg::*;

`ifdef ACC_LOAD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_data;
  logic [1:0]  src_sel;
  logic [1:0]  op;
  logic        req_valid, out_ack;
  logic        req_ready, aout_valid, zero, carry, sel_err;
  logic [7:0]  aout;

  logic [39:0] src5;
  logic [2:0]  sel5;
  logic [1:0]  op5;
  logic        v5, ack5, rdy5, vld5, zero5, carry5, err5;
  logic [7:0]  aout5;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acc_load_unit dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_sel(src_sel), .op(op),
    .req_valid(req_valid), .req_ready(req_ready), .aout(aout), .aout_valid(aout_valid),
    .out_ack(out_ack), .zero(zero), .carry(carry), .sel_err(sel_err)
  );

  acc_load_unit #(.WIDTH(8), .NSRC(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .src_data(src5), .src_sel(sel5), .op(op5),
    .req_valid(v5), .req_ready(rdy5), .aout(aout5), .aout_valid(vld5),
    .out_ack(ack5), .zero(zero5), .carry(carry5), .sel_err(err5)
  );

  typedef struct {
    logic       valid;
    logic       ack;
    logic [1:0] op;
    logic [1:0] sel;
    logic       exp_rdy;
    logic [7:0] exp_aout;
    logic       exp_vld;
    logic       exp_zero;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; src_data = {8'hFF, 8'hA5, 8'h3C, 8'h11};
    src_sel = '0; op = OP_LOAD; req_valid = 1'b0; out_ack = 1'b0;
    src5 = {8'h77, 8'hFF, 8'hA5, 8'h3C, 8'h11};
    sel5 = '0; op5 = OP_LOAD; v5 = 1'b0; ack5 = 1'b0;

    // valid ack op sel | rdy aout vld zero carry
    vecs[0] = '{1'b0, 1'b0, OP_LOAD,  2'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, OP_LOAD,  2'd2, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, OP_LOAD,  2'd1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, OP_LOAD,  2'd3, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, OP_INC,   2'd0, 1'b1, SAT ? 8'hFF : 8'h00, 1'b1, !SAT, 1'b1};
    vecs[5] = '{1'b1, 1'b1, OP_DEC,   2'd0, 1'b1, SAT ? 8'hFE : 8'hFF, 1'b1, 1'b0, !SAT};
    vecs[6] = '{1'b1, 1'b1, OP_CLEAR, 2'd0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, OP_DEC,   2'd0, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b1, SAT, 1'b1};
    vecs[8] = '{1'b0, 1'b1, OP_LOAD,  2'd0, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b0, SAT, 1'b1};
    vecs[9] = '{1'b1, 1'b0, OP_INC,   2'd0, 1'b1, SAT ? 8'h01 : 8'h00, 1'b1, !SAT, !SAT};

    // Reset state, then release with no request
    #12;
    chk("rst_aout", aout, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_vld", aout_valid, 1'b0);
    chk("rst_rdy", req_ready, 1'b1);
    chk("rst_carry", carry, 1'b0);
    chk("rst_err", sel_err, 1'b0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_aout", aout, 8'h00);
    chk("idle_vld", aout_valid, 1'b0);
    chk("idle_zero", zero, 1'b1);

    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].valid; out_ack = vecs[i].ack;
      op = vecs[i].op; src_sel = vecs[i].sel;
      #1;
      chk($sformatf("v%0d_rdy", i), req_ready, vecs[i].exp_rdy);
      tick();
      chk($sformatf("v%0d_aout", i), aout, vecs[i].exp_aout);
      chk($sformatf("v%0d_vld", i), aout_valid, vecs[i].exp_vld);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].exp_zero);
      chk($sformatf("v%0d_carry", i), carry, vecs[i].exp_carry);
      chk($sformatf("v%0d_err", i), sel_err, 1'b0);
    end

    // Backpressure: held A5 survives a pending request until out_ack
    req_valid = 1'b1; out_ack = 1'b1; op = OP_LOAD; src_sel = 2'd2;
    tick();
    chk("bp_load", aout, 8'hA5);
    src_sel = 2'd1; out_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), req_ready, 1'b0);
      tick();
      chk($sformatf("bp_hold%0d", i), aout, 8'hA5);
      chk($sformatf("bp_vld%0d", i), aout_valid, 1'b1);
    end
    out_ack = 1'b1;
    #1;
    chk("bp_rdy_ack", req_ready, 1'b1);
    tick();
    chk("bp_new", aout, 8'h3C);
    chk("bp_new_vld", aout_valid, 1'b1);
    req_valid = 1'b0; out_ack = 1'b0;

    // NSRC=5: out-of-range select
    v5 = 1'b1; ack5 = 1'b1; op5 = OP_LOAD; sel5 = 3'd4;
    tick();
    chk("n5_load4", aout5, 8'h77);
    chk("n5_err0", err5, 1'b0);
    sel5 = 3'd6;
    tick();
    chk("n5_oor_aout", aout5, 8'h00);
    chk("n5_oor_err", err5, 1'b1);
    chk("n5_oor_zero", zero5, 1'b1);
    op5 = OP_CLEAR;
    tick();
    chk("n5_clr_err", err5, 1'b0);
    chk("n5_clr_aout", aout5, 8'h00);
    v5 = 1'b0; ack5 = 1'b0;

    // Asynchronous reset while a result is held
    tick();
    chk("ar_pre_aout", aout, 8'h3C);
    chk("ar_pre_vld", aout_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_aout", aout, 8'h00);
    chk("ar_vld", aout_valid, 1'b0);
    chk("ar_zero", zero, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
